// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display with a double-buffered value.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
module digit_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  sel,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic             frame_q, frame_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;

  logic             slot_last;
  logic             commit;
  logic [3:0]       digit_on;
  logic [3:0]       blank_mask;

  always_comb begin
    slot_last = (div_cnt_q == CNT_LAST);
    commit    = slot_last && (idx_q == 2'd3);
    digit_on  = 4'b0001 << idx_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Blanking follows disp, so it can only change at a commit.
    blank_mask = {(disp_q[15:12] == 4'h0),
                  (disp_q[15:8]  == 8'h00),
                  (disp_q[15:4]  == 12'h000),
                  1'b0};
`else
    blank_mask = 4'b0000;
`endif

    div_cnt_d = slot_last ? '0 : div_cnt_q + 1'b1;
    idx_d     = slot_last ? idx_q + 2'd1 : idx_q;
    shadow_d  = load ? value : shadow_q;
    // disp takes the shadow as it was before this edge, even when a load coincides.
    disp_d    = commit ? shadow_q : disp_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    frame_d = commit;
    sel_d   = disp_q[{idx_q, 2'b00} +: 4];
    an_d    = slot_last ? 4'b1111 : (~digit_on | blank_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      disp_q    <= 16'h0000;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      sel_q     <= 4'h0;
      an_q      <= 4'b1111;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
    end
  end

  assign sel     = sel_q;
  assign an      = an_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule
